// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: BCD time packing,
// lap recall state encoding and default sizes.
package stopwatch_pkg;

  localparam int TIME_W = 20;

  localparam int HUND_LSB   = 0;
  localparam int TENTHS_LSB = 4;
  localparam int ONES_LSB   = 8;
  localparam int TENS_LSB   = 12;
  localparam int MIN_LSB    = 16;

  localparam int DEFAULT_LAP_DEPTH = 8;
  localparam int DEFAULT_TIMEOUT   = 500;

  typedef enum logic {
    ST_LIVE   = 1'b0,
    ST_RECALL = 1'b1
  } lap_state_t;

  function automatic logic [TIME_W-1:0] bcd_time(
    input logic [3:0] mins,
    input logic [3:0] tens,
    input logic [3:0] ones,
    input logic [3:0] tenths,
    input logic [3:0] hund
  );
    logic [TIME_W-1:0] t;
    t = '0;
    t[MIN_LSB+:4]    = mins;
    t[TENS_LSB+:4]   = tens;
    t[ONES_LSB+:4]   = ones;
    t[TENTHS_LSB+:4] = tenths;
    t[HUND_LSB+:4]   = hund;
    return t;
  endfunction

endpackage

// File: rtl/lap_recall_ctrl_if.sv
// Lap recall control/display bundle between the
// timer side and the lap store.
interface lap_recall_ctrl_if
  import stopwatch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_LAP_DEPTH
);

  localparam int IW = $clog2(DEPTH);

  logic              lap_trig;
  logic              recall;
  logic              clear;
  logic [TIME_W-1:0] live_time;
  logic [TIME_W-1:0] disp_time;
  logic [IW-1:0]     disp_idx;
  logic              recall_active;
  logic [IW:0]       count;
  logic              full;
  logic              overflow;

  modport master (
    output lap_trig, recall, clear, live_time,
    input  disp_time, disp_idx, recall_active,
    input  count, full, overflow
  );

  modport slave (
    input  lap_trig, recall, clear, live_time,
    output disp_time, disp_idx, recall_active,
    output count, full, overflow
  );

endinterface

// File: rtl/lap_ram.sv
// Lap storage: DEPTH x TIME_W register file,
// synchronous write, combinational read.
module lap_ram
  import stopwatch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_LAP_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [TIME_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [TIME_W-1:0]        rdata
);

  logic [TIME_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lap_recall_ctrl.sv
// Lap capture ring buffer plus recall walk and
// live/recalled display selection.
module lap_recall_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_LAP_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic              clk,
  input logic              reset_n,
  lap_recall_ctrl_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  lap_state_t        state, state_n;
  logic              recall_q;
  logic [IW-1:0]     wr_ptr, wr_n;
  logic [IW-1:0]     rd_ptr, rd_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              ovf, ovf_n;
  logic [IW-1:0]     idx, idx_n;
  logic              act, act_n;
  logic [TIME_W-1:0] disp, disp_n;
  logic [TW-1:0]     tmo, tmo_n;

  logic              edge_det;
  logic              cap;
  logic [IW-1:0]     raddr;
  logic [TIME_W-1:0] rdata;

  assign edge_det = bus.recall & ~recall_q;
  assign cap      = bus.lap_trig & ~bus.clear;

  // rd_ptr names the slot on show; both entry and step read one slot back
  assign raddr = ((state == ST_LIVE) ? wr_ptr : rd_ptr) - IW'(1);

  lap_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (cap),
    .waddr (wr_ptr),
    .wdata (bus.live_time),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_LIVE;
      recall_q <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      idx      <= '0;
      act      <= 1'b0;
      disp     <= '0;
      tmo      <= '0;
    end else begin
      state    <= state_n;
      recall_q <= bus.recall;
      wr_ptr   <= wr_n;
      rd_ptr   <= rd_n;
      cnt      <= cnt_n;
      ovf      <= ovf_n;
      idx      <= idx_n;
      act      <= act_n;
      disp     <= disp_n;
      tmo      <= tmo_n;
    end
  end

  always_comb begin
    state_n = state;
    wr_n    = wr_ptr;
    rd_n    = rd_ptr;
    cnt_n   = cnt;
    ovf_n   = ovf;
    idx_n   = idx;
    act_n   = act;
    disp_n  = disp;
    tmo_n   = tmo;

    if (cap) begin
      wr_n = wr_ptr + IW'(1);
      if (cnt == FULL_CNT) ovf_n = 1'b1;
      else                 cnt_n = cnt + CW'(1);
    end

    unique case (state)
      ST_LIVE: begin
        disp_n = bus.live_time;
        idx_n  = '0;
        act_n  = 1'b0;
        tmo_n  = '0;
        if (edge_det && cnt != '0) begin
          state_n = ST_RECALL;
          rd_n    = wr_ptr - IW'(1);
          idx_n   = cnt[IW-1:0] - IW'(1);
          act_n   = 1'b1;
          disp_n  = rdata;
        end
      end
      ST_RECALL: begin
        if (edge_det) begin
          tmo_n = '0;
          if (idx == '0) begin
            state_n = ST_LIVE;
            act_n   = 1'b0;
          end else begin
            rd_n   = rd_ptr - IW'(1);
            idx_n  = idx - IW'(1);
            disp_n = rdata;
          end
        end else if (tmo == TMO_LAST) begin
          state_n = ST_LIVE;
          act_n   = 1'b0;
          idx_n   = '0;
          tmo_n   = '0;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      end
      default: state_n = ST_LIVE;
    endcase

    if (bus.clear) begin
      state_n = ST_LIVE;
      wr_n    = '0;
      cnt_n   = '0;
      ovf_n   = 1'b0;
      idx_n   = '0;
      act_n   = 1'b0;
      tmo_n   = '0;
      disp_n  = (state == ST_LIVE) ? bus.live_time : disp;
    end
  end

  assign bus.disp_time     = disp;
  assign bus.disp_idx      = idx;
  assign bus.recall_active = act;
  assign bus.count         = cnt;
  assign bus.full          = (cnt == FULL_CNT);
  assign bus.overflow      = ovf;

endmodule

// File: tb/tb_lap_recall_ctrl.sv
// Directed bench for lap_recall_ctrl with
// hand-computed expected values.
module tb_lap_recall_ctrl;
  import stopwatch_pkg::*;

  localparam int DEPTH = 8;
  localparam int TMO   = 500;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  lap_recall_ctrl_if #(.DEPTH(DEPTH)) bus ();

  lap_recall_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lap(input logic [TIME_W-1:0] t);
    bus.live_time = t;
    bus.lap_trig  = 1'b1;
    cyc();
    bus.lap_trig  = 1'b0;
  endtask

  task automatic redge();
    bus.recall = 1'b1;
    cyc();
    bus.recall = 1'b0;
    cyc();
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.disp_time !== 20'h0) begin
      $display("FAIL rst_disp got %h want 0", bus.disp_time);
      errors++;
    end
    checks++;
    if ({bus.disp_idx, bus.recall_active} !== 4'h0) begin
      $display("FAIL rst_idx_act got %h/%b want 0/0",
               bus.disp_idx, bus.recall_active);
      errors++;
    end
    checks++;
    if ({bus.count, bus.full, bus.overflow} !== 6'h0) begin
      $display("FAIL rst_cnt got %0d/%b/%b want 0/0/0",
               bus.count, bus.full, bus.overflow);
      errors++;
    end
  endtask

  task automatic test_basic();
    logic [TIME_W-1:0] exp [3];
    exp[0] = bcd_time(0, 0, 1, 2, 3);
    exp[1] = bcd_time(0, 0, 2, 5, 0);
    exp[2] = bcd_time(0, 0, 3, 0, 7);
    for (int i = 0; i < 3; i++) lap(exp[i]);
    bus.live_time = 20'h55555;
    cyc();
    checks++;
    if (bus.count !== 4'd3) begin
      $display("FAIL basic_cnt got %0d want 3", bus.count);
      errors++;
    end
    for (int i = 2; i >= 0; i--) begin
      redge();
      checks++;
      if (bus.disp_time !== exp[i] || bus.disp_idx !== 3'(i)
          || bus.recall_active !== 1'b1) begin
        $display("FAIL basic_step%0d got %h/%0d/%b want %h/%0d/1",
                 i, bus.disp_time, bus.disp_idx,
                 bus.recall_active, exp[i], i);
        errors++;
      end
    end
    redge();
    checks++;
    if (bus.recall_active !== 1'b0 || bus.disp_time !== 20'h55555) begin
      $display("FAIL basic_exit got %b/%h want 0/55555",
               bus.recall_active, bus.disp_time);
      errors++;
    end
  endtask

  task automatic test_overflow();
    do_clear();
    checks++;
    if (bus.count !== 4'd0) begin
      $display("FAIL ovf_clr got %0d want 0", bus.count);
      errors++;
    end
    for (int k = 1; k <= 9; k++) lap(bcd_time(0, 0, 4'(k), 0, 0));
    checks++;
    if (bus.count !== 4'd8 || bus.full !== 1'b1 || bus.overflow !== 1'b1) begin
      $display("FAIL ovf_flags got %0d/%b/%b want 8/1/1",
               bus.count, bus.full, bus.overflow);
      errors++;
    end
    redge();
    checks++;
    if (bus.disp_time !== 20'h00900 || bus.disp_idx !== 3'd7) begin
      $display("FAIL ovf_newest got %h/%0d want 00900/7",
               bus.disp_time, bus.disp_idx);
      errors++;
    end
    for (int i = 0; i < 7; i++) redge();
    checks++;
    if (bus.disp_time !== 20'h00200 || bus.disp_idx !== 3'd0) begin
      $display("FAIL ovf_oldest got %h/%0d want 00200/0",
               bus.disp_time, bus.disp_idx);
      errors++;
    end
    redge();
    checks++;
    if (bus.recall_active !== 1'b0) begin
      $display("FAIL ovf_exit got %b want 0", bus.recall_active);
      errors++;
    end
  endtask

  task automatic test_empty_recall();
    do_clear();
    bus.live_time = 20'h12345;
    redge();
    checks++;
    if (bus.recall_active !== 1'b0 || bus.disp_time !== 20'h12345) begin
      $display("FAIL empty_edge got %b/%h want 0/12345",
               bus.recall_active, bus.disp_time);
      errors++;
    end
    bus.live_time = 20'h00777;
    cyc();
    checks++;
    if (bus.disp_time !== 20'h00777 || bus.disp_idx !== 3'd0) begin
      $display("FAIL empty_track got %h/%0d want 00777/0",
               bus.disp_time, bus.disp_idx);
      errors++;
    end
  endtask

  task automatic test_timeout();
    do_clear();
    lap(20'h00111);
    lap(20'h00222);
    bus.live_time = 20'h04444;
    bus.recall = 1'b1;
    cyc();
    bus.recall = 1'b0;
    repeat (TMO - 1) cyc();
    checks++;
    if (bus.recall_active !== 1'b1 || bus.disp_time !== 20'h00222) begin
      $display("FAIL tmo_early got %b/%h want 1/00222",
               bus.recall_active, bus.disp_time);
      errors++;
    end
    cyc();
    checks++;
    if (bus.recall_active !== 1'b0 || bus.disp_idx !== 3'd0) begin
      $display("FAIL tmo_exit got %b/%0d want 0/0",
               bus.recall_active, bus.disp_idx);
      errors++;
    end
    cyc();
    checks++;
    if (bus.disp_time !== 20'h04444) begin
      $display("FAIL tmo_live got %h want 04444", bus.disp_time);
      errors++;
    end
    bus.recall = 1'b1;
    cyc();
    bus.recall = 1'b0;
    repeat (TMO - 2) cyc();
    bus.recall = 1'b1;
    cyc();
    bus.recall = 1'b0;
    checks++;
    if (bus.disp_idx !== 3'd0 || bus.disp_time !== 20'h00111) begin
      $display("FAIL tmo_step got %0d/%h want 0/00111",
               bus.disp_idx, bus.disp_time);
      errors++;
    end
    repeat (TMO - 1) cyc();
    checks++;
    if (bus.recall_active !== 1'b1) begin
      $display("FAIL tmo_restart got %b want 1", bus.recall_active);
      errors++;
    end
    cyc();
    checks++;
    if (bus.recall_active !== 1'b0) begin
      $display("FAIL tmo_exit2 got %b want 0", bus.recall_active);
      errors++;
    end
  endtask

  task automatic test_clear_priority();
    do_clear();
    for (int k = 1; k <= 5; k++) lap(bcd_time(0, 1, 4'(k), 0, 0));
    redge();
    checks++;
    if (bus.disp_idx !== 3'd4 || bus.disp_time !== 20'h01500) begin
      $display("FAIL clr_enter got %0d/%h want 4/01500",
               bus.disp_idx, bus.disp_time);
      errors++;
    end
    bus.live_time = 20'h09999;
    bus.clear     = 1'b1;
    bus.lap_trig  = 1'b1;
    cyc();
    bus.clear     = 1'b0;
    bus.lap_trig  = 1'b0;
    checks++;
    if (bus.count !== 4'd0 || bus.overflow !== 1'b0
        || bus.recall_active !== 1'b0) begin
      $display("FAIL clr_prio got %0d/%b/%b want 0/0/0",
               bus.count, bus.overflow, bus.recall_active);
      errors++;
    end
    lap(20'h00042);
    bus.live_time = 20'h00001;
    redge();
    checks++;
    if (bus.count !== 4'd1 || bus.disp_idx !== 3'd0
        || bus.disp_time !== 20'h00042) begin
      $display("FAIL clr_drop got %0d/%0d/%h want 1/0/00042",
               bus.count, bus.disp_idx, bus.disp_time);
      errors++;
    end
    redge();
  endtask

  task automatic test_reset_mid();
    do_clear();
    for (int k = 1; k <= 4; k++) lap(bcd_time(0, 2, 4'(k), 0, 0));
    redge();
    checks++;
    if (bus.disp_idx !== 3'd3 || bus.recall_active !== 1'b1) begin
      $display("FAIL rmid_enter got %0d/%b want 3/1",
               bus.disp_idx, bus.recall_active);
      errors++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.disp_time !== 20'h0 || bus.disp_idx !== 3'd0
        || bus.recall_active !== 1'b0 || bus.count !== 4'd0
        || bus.full !== 1'b0 || bus.overflow !== 1'b0) begin
      $display("FAIL rmid_async got %h/%0d/%b/%0d want all zero",
               bus.disp_time, bus.disp_idx,
               bus.recall_active, bus.count);
      errors++;
    end
    cyc();
    reset_n = 1'b1;
    bus.live_time = 20'h00303;
    cyc();
    redge();
    checks++;
    if (bus.recall_active !== 1'b0 || bus.count !== 4'd0
        || bus.disp_time !== 20'h00303) begin
      $display("FAIL rmid_empty got %b/%0d/%h want 0/0/00303",
               bus.recall_active, bus.count, bus.disp_time);
      errors++;
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset_n       = 1'b0;
    bus.lap_trig  = 1'b0;
    bus.recall    = 1'b0;
    bus.clear     = 1'b0;
    bus.live_time = 20'h0;
    #12;
    test_reset();
    reset_n = 1'b1;
    cyc();
    test_basic();
    test_overflow();
    test_empty_recall();
    test_timeout();
    test_clear_priority();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
